// File: rtl/stage2_maxpool_if.sv
// Streaming pixel bus between the stage-2 conv core and the 2x2 max-pool stage.
// The master drives pixels in; the slave returns pooled pixels and the frame marker.
interface stage2_maxpool_if #(
  parameter int unsigned CH  = 3,
  parameter int unsigned IBW = 32
);
  logic                i_in_valid;
  logic [CH*IBW-1:0]   i_in_fmap;
  logic                o_ot_valid;
  logic [CH*IBW-1:0]   o_ot_fmap;
  logic                o_frame_done;

  modport master (
    output i_in_valid,
    output i_in_fmap,
    input  o_ot_valid,
    input  o_ot_fmap,
    input  o_frame_done
  );

  modport slave (
    input  i_in_valid,
    input  i_in_fmap,
    output o_ot_valid,
    output o_ot_fmap,
    output o_frame_done
  );
endinterface

// File: rtl/stage2_maxpool.sv
// Streaming 2x2 stride-2 max-pool over a raster-ordered IN_X x IN_Y map, all channels in parallel.
// Keeps one hold register and one half-row buffer of pair maxima per channel.
module stage2_maxpool #(
  parameter int unsigned CH   = 3,
  parameter int unsigned IBW  = 32,
  parameter int unsigned IN_X = 8,
  parameter int unsigned IN_Y = 8
) (
  input logic               clk,
  input logic               reset,
  stage2_maxpool_if.slave   bus
);
  localparam int unsigned CW = (IN_X > 2) ? $clog2(IN_X) : 1;
  localparam int unsigned RW = (IN_Y > 2) ? $clog2(IN_Y) : 1;
  localparam int unsigned HX = IN_X / 2;
  localparam int unsigned HW = (HX > 1) ? $clog2(HX) : 1;

  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [IBW-1:0]    r_h  [CH];
  logic [IBW-1:0]    r_rb [CH][HX];
  logic              r_ot_valid;
  logic              r_frame_done;
  logic [CH*IBW-1:0] r_ot_fmap;

  logic              w_col_last;
  logic              w_row_last;
  logic              w_emit;
  logic [HW-1:0]     w_half;
  logic [IBW-1:0]    w_in   [CH];
  logic [IBW-1:0]    w_pair [CH];
  logic [CH*IBW-1:0] w_pool;

  assign w_col_last = (r_col == CW'(IN_X - 1));
  assign w_row_last = (r_row == RW'(IN_Y - 1));
  assign w_half     = r_col[HW:1];
  assign w_emit     = bus.i_in_valid & r_col[0] & r_row[0];

  // Unsigned per-channel maxima: horizontal pair, then against the buffered pair above.
  always_comb begin
    w_pool = '0;
    for (int unsigned c = 0; c < CH; c++) begin
      w_in[c]   = bus.i_in_fmap[c*IBW +: IBW];
      w_pair[c] = (w_in[c] > r_h[c]) ? w_in[c] : r_h[c];
      w_pool[c*IBW +: IBW] = (r_rb[c][w_half] > w_pair[c]) ? r_rb[c][w_half] : w_pair[c];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (bus.i_in_valid) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned c = 0; c < CH; c++) begin
        r_h[c] <= '0;
        for (int unsigned i = 0; i < HX; i++) begin
          r_rb[c][i] <= '0;
        end
      end
    end else if (bus.i_in_valid) begin
      for (int unsigned c = 0; c < CH; c++) begin
        if (!r_col[0]) begin
          r_h[c] <= w_in[c];
        end else if (!r_row[0]) begin
          r_rb[c][w_half] <= w_pair[c];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ot_valid   <= 1'b0;
      r_frame_done <= 1'b0;
      r_ot_fmap    <= '0;
    end else begin
      r_ot_valid   <= w_emit;
      r_frame_done <= w_emit & w_row_last & w_col_last;
      if (w_emit) begin
        r_ot_fmap <= w_pool;
      end
    end
  end

  assign bus.o_ot_valid   = r_ot_valid;
  assign bus.o_ot_fmap    = r_ot_fmap;
  assign bus.o_frame_done = r_frame_done;
endmodule

// File: tb/tb_stage2_maxpool.sv
// Directed bench for stage2_maxpool: ramp, per-channel, window-position, gaps, back-to-back
// frames and mid-frame reset, checked against a full-window reference maximum.
module tb_stage2_maxpool;
  localparam int unsigned CH  = 3;
  localparam int unsigned IBW = 32;
  localparam int NX = 8;
  localparam int NY = 8;
  localparam int W  = CH * IBW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  stage2_maxpool_if #(.CH(CH), .IBW(IBW)) bus ();

  stage2_maxpool #(.CH(CH), .IBW(IBW), .IN_X(NX), .IN_Y(NY)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int n_out;
  int n_done;
  logic [IBW-1:0] pix [CH][NY][NX];
  logic [W-1:0]   last_exp;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pool_exp(int pr, int pc);
    logic [W-1:0]   w;
    logic [IBW-1:0] m;
    w = '0;
    for (int c = 0; c < CH; c++) begin
      m = '0;
      for (int dy = 0; dy < 2; dy++)
        for (int dx = 0; dx < 2; dx++)
          if (pix[c][2*pr+dy][2*pc+dx] > m) m = pix[c][2*pr+dy][2*pc+dx];
      w[c*IBW +: IBW] = m;
    end
    return w;
  endfunction

  task automatic fill_ramp(input int offset);
    for (int c = 0; c < CH; c++)
      for (int r = 0; r < NY; r++)
        for (int x = 0; x < NX; x++)
          pix[c][r][x] = IBW'(r * NX + x + offset);
  endtask

  task automatic idle();
    bus.i_in_valid = 1'b0;
    @(posedge clk); #1;
    chk("idle_valid", W'(bus.o_ot_valid), '0);
    chk("idle_done", W'(bus.o_frame_done), '0);
    chk("idle_hold_fmap", bus.o_ot_fmap, last_exp);
  endtask

  task automatic send(input int r, input int x);
    logic odd;
    bus.i_in_valid = 1'b1;
    for (int c = 0; c < CH; c++) bus.i_in_fmap[c*IBW +: IBW] = pix[c][r][x];
    @(posedge clk); #1;
    bus.i_in_valid = 1'b0;
    odd = (r % 2 == 1) && (x % 2 == 1);
    chk("out_valid", W'(bus.o_ot_valid), W'(odd));
    chk("frame_done", W'(bus.o_frame_done), W'(odd && r == NY - 1 && x == NX - 1));
    if (odd) begin
      last_exp = pool_exp(r / 2, x / 2);
      chk("pool_value", bus.o_ot_fmap, last_exp);
    end
    if (bus.o_ot_valid === 1'b1) n_out++;
    if (bus.o_frame_done === 1'b1) n_done++;
  endtask

  task automatic frame(input bit gaps, input int limit);
    for (int r = 0; r < NY; r++)
      for (int x = 0; x < NX; x++)
        if (r * NX + x < limit) begin
          if (gaps) begin
            int k;
            k = $urandom_range(0, 1);
            for (int i = 0; i < k; i++) idle();
          end
          send(r, x);
        end
  endtask

  task automatic do_reset_check(input string tag);
    reset = 1'b1;
    #1;
    chk({tag, "_valid"}, W'(bus.o_ot_valid), '0);
    chk({tag, "_fmap"}, bus.o_ot_fmap, '0);
    chk({tag, "_done"}, W'(bus.o_frame_done), '0);
    last_exp = '0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    bus.i_in_valid = 1'b0;
    bus.i_in_fmap  = '0;
    last_exp       = '0;
    #12;
    chk("rst_valid", W'(bus.o_ot_valid), '0);
    chk("rst_fmap", bus.o_ot_fmap, '0);
    chk("rst_done", W'(bus.o_frame_done), '0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Ramp frame, continuous valid
    fill_ramp(0);
    n_out = 0; n_done = 0;
    frame(1'b0, 64);
    chk("ramp_count", W'(n_out), W'(16));
    chk("ramp_done_count", W'(n_done), W'(1));
    chk("ramp_last", bus.o_ot_fmap, {3{32'd63}});
    idle();

    // Per-channel independence and unsigned compare
    for (int r = 0; r < NY; r++)
      for (int x = 0; x < NX; x++) begin
        pix[0][r][x] = IBW'(r * NX + x);
        pix[1][r][x] = IBW'(63 - (r * NX + x));
        pix[2][r][x] = 32'h8000_0000;
      end
    frame(1'b0, 64);
    chk("chan_last", bus.o_ot_fmap, {32'h8000_0000, 32'd9, 32'd63});

    // Single maximum at each position of window (0,0)
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < CH; c++) begin
        for (int r = 0; r < NY; r++)
          for (int x = 0; x < NX; x++) pix[c][r][x] = '0;
        pix[c][p / 2][p % 2] = 32'hFFFF_FFFF;
      end
      frame(1'b0, 64);
      chk("winpos_last_zero", bus.o_ot_fmap, '0);
    end

    // Random gaps on the ramp
    fill_ramp(0);
    n_out = 0; n_done = 0;
    frame(1'b1, 64);
    chk("gap_count", W'(n_out), W'(16));
    chk("gap_done_count", W'(n_done), W'(1));

    // Two back-to-back frames, no idle between
    n_out = 0; n_done = 0;
    fill_ramp(0);
    frame(1'b0, 64);
    fill_ramp(100);
    frame(1'b0, 64);
    chk("b2b_count", W'(n_out), W'(32));
    chk("b2b_done_count", W'(n_done), W'(2));
    chk("b2b_last", bus.o_ot_fmap, {3{32'd163}});
    idle();

    // Reset while an output is valid, then after 20 inputs, then a clean frame
    fill_ramp(0);
    frame(1'b0, 10);
    chk("pre_reset_valid", W'(bus.o_ot_valid), W'(1));
    do_reset_check("rst_mid_out");
    frame(1'b0, 20);
    do_reset_check("rst_after20");
    idle();
    n_out = 0; n_done = 0;
    frame(1'b0, 64);
    chk("post_reset_count", W'(n_out), W'(16));
    chk("post_reset_done_count", W'(n_done), W'(1));
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench time limit expired");
  end
endmodule
